// File: rtl/affine_rf_bank_pkg.sv
// rtl/affine_rf_bank_pkg.sv - shared width, write-mode encoding and saturating add
// Purpose: package affine, imported by the register bank, its FIFO and its interface.
// Ports: none (package).
package affine;

  localparam int N = 16;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    BCAST  = 2'b01,
    ACCUM  = 2'b10,
    WM_RSV = 2'b11
  } wmode_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] sum;
  } sat_t;

  // Saturating add for a w-bit signed datapath (w <= 62). Operands arrive
  // sign-extended to 64 bits so the raw sum can never wrap; the result is
  // clamped to [-2^(w-1), 2^(w-1)-1] and ovf reports whether a clamp happened.
  function automatic sat_t sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] s;
    sat_t               r;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    s     = a + b;
    r.ovf = 1'b0;
    r.sum = s;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/affine_rf_bank_if.sv
// rtl/affine_rf_bank_if.sv - bus bundle between sample source/ALU and the register bank
// Purpose: groups every non-clock, non-reset signal of affine_rf_bank.
// Ports: ext_* FIFO handshake, we/wmode/wd_* write port, rs/rd read ports,
//        acc_o flattened accumulators, ovf_o/clr_ovf_i sticky saturation flag.
// Modports: master drives the *_i signals, slave (the bank) drives the *_o signals.
interface affine_rf_bank_if #(
  parameter int N       = affine::N,
  parameter int NUM_ACC = 2,
  parameter int AW      = 3,
  parameter int CW      = 3
);
  logic               ext_valid_i;
  logic [N-1:0]       ext_data_i;
  logic               ext_ready_o;
  logic               ext_pop_i;
  logic               ext_avail_o;
  logic [CW-1:0]      ext_count_o;
  logic               we_i;
  logic [1:0]         wmode_i;
  logic [AW-1:0]      wd_addr_i;
  logic [N-1:0]       wd_data_i;
  logic [AW-1:0]      rs_addr_i;
  logic [AW-1:0]      rd_addr_i;
  logic [N-1:0]       rs_data_o;
  logic [N-1:0]       rd_data_o;
  logic [NUM_ACC*N-1:0] acc_o;
  logic               ovf_o;
  logic               clr_ovf_i;

  modport master (
    output ext_valid_i, ext_data_i, ext_pop_i, we_i, wmode_i, wd_addr_i, wd_data_i,
           rs_addr_i, rd_addr_i, clr_ovf_i,
    input  ext_ready_o, ext_avail_o, ext_count_o, rs_data_o, rd_data_o, acc_o, ovf_o
  );

  modport slave (
    input  ext_valid_i, ext_data_i, ext_pop_i, we_i, wmode_i, wd_addr_i, wd_data_i,
           rs_addr_i, rd_addr_i, clr_ovf_i,
    output ext_ready_o, ext_avail_o, ext_count_o, rs_data_o, rd_data_o, acc_o, ovf_o
  );
endinterface

// File: rtl/affine_ext_fifo.sv
// rtl/affine_ext_fifo.sv - external sample FIFO with valid/ready push and pop
// Purpose: EXT_DEPTH-entry FIFO, no fall-through; ready/avail decode registered count.
// Ports: clk_i, rst_i (async, active-high); push_valid_i/push_data_i/ready_o push side;
//        pop_i/avail_o/head_o pop side; count_o occupancy.
module affine_ext_fifo #(
  parameter int N         = 16,
  parameter int EXT_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_valid_i,
  input  logic [N-1:0]                 push_data_i,
  output logic                         ready_o,
  input  logic                         pop_i,
  output logic                         avail_o,
  output logic [$clog2(EXT_DEPTH):0]   count_o,
  output logic [N-1:0]                 head_o
);
  localparam int          PW   = $clog2(EXT_DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(EXT_DEPTH);

  logic [N-1:0]  mem_q [EXT_DEPTH];
  logic [N-1:0]  mem_d [EXT_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push, pop;

  assign ready_o = (count_q != FULL);
  assign avail_o = (count_q != '0);
  assign count_o = count_q;
  assign head_o  = avail_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push     = push_valid_i && ready_o;
    pop      = pop_i && avail_o;
    if (push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/affine_rf_bank.sv
// rtl/affine_rf_bank.sv - register bank feeding the affine ALU operands and accumulators
// Purpose: temps, accumulators (single/broadcast/saturating-accumulate writes), read
//          bypass, sticky overflow, and the external sample FIFO mapped at address 0.
// Ports: clk_i clock, rst_i async active-high reset, bus (affine_rf_bank_if.slave).
module affine_rf_bank
  import affine::*;
#(
  parameter int N         = affine::N,
  parameter int NUM_TMP   = 2,
  parameter int NUM_ACC   = 2,
  parameter int EXT_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  affine_rf_bank_if.slave   bus
);
  localparam int AW   = $clog2(NUM_TMP + NUM_ACC + 2);
  localparam int NREG = 2 ** AW;
  localparam int ACC0 = NUM_TMP + 1;

  logic signed [N-1:0] tmp_q [NUM_TMP];
  logic signed [N-1:0] tmp_d [NUM_TMP];
  logic signed [N-1:0] acc_q [NUM_ACC];
  logic signed [N-1:0] acc_d [NUM_ACC];
  logic                ovf_q, ovf_d;
  logic [N-1:0]        fifo_head;
  logic [N-1:0]        view [NREG];
  sat_t                acc_sum;
  wmode_t              wmode;
  int                  wa;

  assign wmode = wmode_t'(bus.wmode_i);
  assign wa    = int'(bus.wd_addr_i);

  affine_ext_fifo #(.N(N), .EXT_DEPTH(EXT_DEPTH)) u_ext_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_valid_i (bus.ext_valid_i),
    .push_data_i  (bus.ext_data_i),
    .ready_o      (bus.ext_ready_o),
    .pop_i        (bus.ext_pop_i),
    .avail_o      (bus.ext_avail_o),
    .count_o      (bus.ext_count_o),
    .head_o       (fifo_head)
  );

  // Write decode. The clear is applied first so a saturation in the same
  // cycle re-sets the flag (set wins).
  always_comb begin
    tmp_d   = tmp_q;
    acc_d   = acc_q;
    ovf_d   = bus.clr_ovf_i ? 1'b0 : ovf_q;
    acc_sum = '0;
    if (bus.we_i) begin
      case (wmode)
        SINGLE: begin
          for (int k = 0; k < NUM_TMP; k++)
            if (wa == k + 1) tmp_d[k] = bus.wd_data_i;
          for (int k = 0; k < NUM_ACC; k++)
            if (wa == ACC0 + k) acc_d[k] = bus.wd_data_i;
        end
        BCAST: begin
          for (int k = 0; k < NUM_ACC; k++) acc_d[k] = bus.wd_data_i;
        end
        ACCUM: begin
          for (int k = 0; k < NUM_ACC; k++) begin
            if (wa == ACC0 + k) begin
              acc_sum  = sat_add(64'(acc_q[k]), 64'(signed'(bus.wd_data_i)), N);
              acc_d[k] = acc_sum.sum[N-1:0];
              if (acc_sum.ovf) ovf_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read view of the whole address space, with SINGLE/BCAST bypass overlaid.
  // ACCUM is deliberately not bypassed so reads see the pre-update value.
  always_comb begin
    for (int i = 0; i < NREG; i++) view[i] = '0;
    view[0] = fifo_head;
    for (int k = 0; k < NUM_TMP; k++) view[k + 1] = tmp_q[k];
    for (int k = 0; k < NUM_ACC; k++) view[ACC0 + k] = acc_q[k];
    if (bus.we_i && wmode == SINGLE && wa >= 1 && wa < ACC0 + NUM_ACC)
      view[bus.wd_addr_i] = bus.wd_data_i;
    if (bus.we_i && wmode == BCAST)
      for (int k = 0; k < NUM_ACC; k++) view[ACC0 + k] = bus.wd_data_i;
  end

  assign bus.rs_data_o = view[bus.rs_addr_i];
  assign bus.rd_data_o = view[bus.rd_addr_i];
  assign bus.ovf_o     = ovf_q;

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_acc_out
    assign bus.acc_o[g*N +: N] = acc_q[g];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmp_q <= '{default: '0};
      acc_q <= '{default: '0};
      ovf_q <= 1'b0;
    end else begin
      tmp_q <= tmp_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_affine_rf_bank.sv
// tb/tb_affine_rf_bank.sv - self-checking bench for affine_rf_bank
module tb_affine_rf_bank;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  affine_rf_bank_if #(.N(16), .NUM_ACC(2), .AW(3), .CW(3)) rf_if ();

  affine_rf_bank #(.N(16), .NUM_TMP(2), .NUM_ACC(2), .EXT_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (rf_if)
  );

  logic [15:0] m_q[$];
  logic [15:0] m_tmp[2];
  int          m_acc[2];
  bit          m_ovf;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_tmp = '{default: '0};
    m_acc = '{default: 0};
    m_ovf = 1'b0;
  endtask

  function automatic logic [15:0] exp_rd(input int a);
    int wa;
    wa = int'(rf_if.wd_addr_i);
    if (rf_if.we_i && rf_if.wmode_i == 2'b00 && a == wa && a >= 1 && a <= 4) return rf_if.wd_data_i;
    if (rf_if.we_i && rf_if.wmode_i == 2'b01 && a >= 3 && a <= 4) return rf_if.wd_data_i;
    if (a == 0) return (m_q.size() > 0) ? m_q[0] : 16'h0;
    if (a <= 2) return m_tmp[a-1];
    if (a <= 4) return 16'(m_acc[a-3]);
    return 16'h0;
  endfunction

  task automatic model_step();
    bit push_ok, pop_ok;
    int a, s;
    push_ok = rf_if.ext_valid_i && (m_q.size() < 4);
    pop_ok  = rf_if.ext_pop_i && (m_q.size() > 0);
    if (pop_ok) void'(m_q.pop_front());
    if (push_ok) m_q.push_back(rf_if.ext_data_i);
    if (rf_if.clr_ovf_i) m_ovf = 1'b0;
    a = int'(rf_if.wd_addr_i);
    if (rf_if.we_i) begin
      case (rf_if.wmode_i)
        2'b00: begin
          if (a >= 1 && a <= 2) m_tmp[a-1] = rf_if.wd_data_i;
          if (a >= 3 && a <= 4) m_acc[a-3] = int'($signed(rf_if.wd_data_i));
        end
        2'b01: begin
          m_acc[0] = int'($signed(rf_if.wd_data_i));
          m_acc[1] = int'($signed(rf_if.wd_data_i));
        end
        2'b10: begin
          if (a >= 3 && a <= 4) begin
            s = m_acc[a-3] + int'($signed(rf_if.wd_data_i));
            if (s > 32767) begin s = 32767; m_ovf = 1'b1; end
            if (s < -32768) begin s = -32768; m_ovf = 1'b1; end
            m_acc[a-3] = s;
          end
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) if (!rst) model_step();

  always @(negedge clk) begin
    chk("ready", 64'(rf_if.ext_ready_o), 64'(m_q.size() < 4));
    chk("avail", 64'(rf_if.ext_avail_o), 64'(m_q.size() > 0));
    chk("count", 64'(rf_if.ext_count_o), 64'(m_q.size()));
    chk("rs_data", 64'(rf_if.rs_data_o), 64'(exp_rd(int'(rf_if.rs_addr_i))));
    chk("rd_data", 64'(rf_if.rd_data_o), 64'(exp_rd(int'(rf_if.rd_addr_i))));
    chk("acc_o", 64'(rf_if.acc_o), 64'({16'(m_acc[1]), 16'(m_acc[0])}));
    chk("ovf", 64'(rf_if.ovf_o), 64'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_if.ext_valid_i = 1'b0;
    rf_if.ext_data_i  = '0;
    rf_if.ext_pop_i   = 1'b0;
    rf_if.we_i        = 1'b0;
    rf_if.wmode_i     = 2'b00;
    rf_if.wd_addr_i   = '0;
    rf_if.wd_data_i   = '0;
    rf_if.rs_addr_i   = '0;
    rf_if.rd_addr_i   = '0;
    rf_if.clr_ovf_i   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] mode, input logic [2:0] addr, input logic [15:0] data);
    rf_if.we_i      = 1'b1;
    rf_if.wmode_i   = mode;
    rf_if.wd_addr_i = addr;
    rf_if.wd_data_i = data;
  endtask

  initial begin
    idle();
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 64'(rf_if.ext_ready_o), 64'd1);
    chk("rst_count", 64'(rf_if.ext_count_o), 64'd0);
    chk("rst_acc", 64'(rf_if.acc_o), 64'd0);
    chk("rst_rd0", 64'(rf_if.rs_data_o), 64'd0);

    for (int i = 0; i < 4; i++) begin
      rf_if.ext_valid_i = 1'b1;
      rf_if.ext_data_i  = 16'hA000 + 16'(i);
      tick();
    end
    rf_if.ext_data_i = 16'hBEEF;
    #1;
    chk("full_ready", 64'(rf_if.ext_ready_o), 64'd0);
    chk("full_count", 64'(rf_if.ext_count_o), 64'd4);
    tick();
    chk("refused_count", 64'(rf_if.ext_count_o), 64'd4);
    rf_if.ext_pop_i = 1'b1;
    tick();
    rf_if.ext_valid_i = 1'b0;
    rf_if.ext_pop_i   = 1'b0;
    #1;
    chk("pop_full_count", 64'(rf_if.ext_count_o), 64'd3);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("fifo_order", 64'(rf_if.rs_data_o), 64'(16'hA001 + 16'(j)));
      rf_if.ext_pop_i = 1'b1;
      tick();
    end
    rf_if.ext_pop_i = 1'b0;
    #1;
    chk("empty_rd0", 64'(rf_if.rs_data_o), 64'd0);
    chk("empty_avail", 64'(rf_if.ext_avail_o), 64'd0);

    wr(2'b00, 3'd1, 16'h1234);
    rf_if.rs_addr_i = 3'd1;
    #1;
    chk("single_bypass", 64'(rf_if.rs_data_o), 64'h1234);
    tick();
    rf_if.we_i = 1'b0;
    #1;
    chk("single_held", 64'(rf_if.rs_data_o), 64'h1234);

    wr(2'b01, 3'd0, 16'h0007);
    rf_if.rd_addr_i = 3'd4;
    #1;
    chk("bcast_bypass", 64'(rf_if.rd_data_o), 64'h7);
    tick();
    idle();
    #1;
    chk("bcast_acc", 64'(rf_if.acc_o), 64'h0007_0007);

    rf_if.ext_valid_i = 1'b1;
    rf_if.ext_data_i  = 16'h55AA;
    tick();
    idle();
    wr(2'b00, 3'd0, 16'hDEAD);
    tick();
    rf_if.we_i = 1'b0;
    #1;
    chk("addr0_wr_ignored", 64'(rf_if.rs_data_o), 64'h55AA);
    rf_if.ext_pop_i = 1'b1;
    tick();
    idle();

    wr(2'b00, 3'd3, 16'h0020);
    tick();
    wr(2'b10, 3'd3, 16'h7FF0);
    rf_if.rs_addr_i = 3'd3;
    #1;
    chk("accum_no_bypass", 64'(rf_if.rs_data_o), 64'h0020);
    tick();
    idle();
    #1;
    chk("sat_acc", 64'(rf_if.acc_o[15:0]), 64'h7FFF);
    chk("sat_ovf", 64'(rf_if.ovf_o), 64'd1);
    rf_if.clr_ovf_i = 1'b1;
    tick();
    rf_if.clr_ovf_i = 1'b0;
    #1;
    chk("clr_ovf", 64'(rf_if.ovf_o), 64'd0);
    rf_if.clr_ovf_i = 1'b1;
    wr(2'b10, 3'd3, 16'h0001);
    tick();
    wr(2'b10, 3'd4, 16'h8000);
    rf_if.clr_ovf_i = 1'b0;
    #1;
    chk("set_wins", 64'(rf_if.ovf_o), 64'd1);
    tick();
    #1;
    chk("neg_acc", 64'(rf_if.acc_o[31:16]), 64'h8007);
    tick();
    wr(2'b10, 3'd1, 16'h0100);
    #1;
    chk("neg_sat", 64'(rf_if.acc_o[31:16]), 64'h8000);
    tick();
    wr(2'b11, 3'd2, 16'hFFFF);
    tick();
    wr(2'b00, 3'd6, 16'hCAFE);
    rf_if.rd_addr_i = 3'd6;
    #1;
    chk("high_addr", 64'(rf_if.rd_data_o), 64'd0);
    tick();
    wr(2'b00, 3'd2, 16'h8421);
    rf_if.rs_addr_i = 3'd2;
    rf_if.rd_addr_i = 3'd1;
    tick();
    idle();

    for (int i = 0; i < 3; i++) begin
      rf_if.ext_valid_i = 1'b1;
      rf_if.ext_data_i  = 16'h0C00 + 16'(i);
      tick();
    end
    idle();
    #1;
    chk("pre_rst_count", 64'(rf_if.ext_count_o), 64'd3);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_count", 64'(rf_if.ext_count_o), 64'd0);
    chk("async_ovf", 64'(rf_if.ovf_o), 64'd0);
    chk("async_acc", 64'(rf_if.acc_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_rd0", 64'(rf_if.rs_data_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/affine_rf_bank.md
# affine_rf_bank

Parametrised register bank for the affine datapath, the next generation of the fixed 5-slot register file. It holds a configurable number of temporary registers and accumulators, buffers external input in a small FIFO with a valid/ready handshake, and supports single, broadcast and saturating-accumulate writes. Everything is on one clock; there are no negedge accumulators. It sits between the external sample source and the affine ALU, and feeds the two ALU operands and the accumulator outputs.

## Interface
- N, default affine::N: datapath width, signed two's complement.
- NUM_TMP, default 2: temporary registers (≥1).
- NUM_ACC, default 2: accumulators (≥1).
- EXT_DEPTH, default 4: external FIFO depth (power of two, ≥2).
- AW (localparam) = $clog2(NUM_TMP+NUM_ACC+2): address width.

Ports:
- clk_i  in  1  clock. All state updates on the rising edge.
- rst_i  in  1  reset. Asynchronous and active-high.
- ext_valid_i  in  1  external data valid.
- ext_data_i  in  N  external sample.
- ext_ready_o  out  1  FIFO not full.
- ext_pop_i  in  1  consume the FIFO head.
- ext_avail_o  out  1  FIFO not empty.
- ext_count_o  out  $clog2(EXT_DEPTH)+1  FIFO occupancy.
- we_i  in  1  write enable.
- wmode_i  in  2  write mode: 00 SINGLE, 01 BCAST, 10 ACCUM, 11 reserved (no write).
- wd_addr_i  in  AW  write address.
- wd_data_i  in  N  write data.
- rs_addr_i, rd_addr_i  in  AW  read addresses.
- rs_data_o, rd_data_o  out  N  read data.
- acc_o  out  NUM_ACC*N  all accumulators, flattened; acc k is at [k*N +: N].
- ovf_o  out  1  sticky saturation flag.
- clr_ovf_i  in  1  clear ovf_o.

## Operation
- Address map:
  - 0 = FIFO head. Reads 0 when the FIFO is empty. Writes to it are ignored.
  - 1..NUM_TMP = temporary registers.
  - NUM_TMP+1..NUM_TMP+NUM_ACC = accumulators.
  - Higher addresses read 0 and ignore writes.
- Push happens when ext_valid_i && ext_ready_o. Pop happens when ext_pop_i && ext_avail_o. A pop on an empty FIFO is ignored.
- Simultaneous push and pop:
  - Not empty and not full: both happen, count unchanged.
  - Full: ready is 0, so only the pop happens.
  - Empty: only the push happens.
- Pointers wrap modulo EXT_DEPTH.
- SINGLE: the register at wd_addr_i gets wd_data_i.
- BCAST: every accumulator gets wd_data_i. wd_addr_i is ignored.
- ACCUM: if wd_addr_i is an accumulator, acc <= sat(acc + wd_data_i). The sum is taken at N+1 bits and clamped to [-2^(N-1), 2^(N-1)-1]. Any clamp sets ovf_o. At a non-accumulator address there is no write.
- ovf_o: clr_ovf_i clears it. If a clear and a new saturation happen in the same cycle, set wins.
- Read bypass:
  - A SINGLE or BCAST write whose target matches a read address returns wd_data_i on that read in the same cycle.
  - ACCUM writes are not bypassed; reads return the pre-update value.
- Reset: all temps, accumulators, FIFO storage and pointers go to 0.
  - ext_ready_o=1, ext_avail_o=0, ext_count_o=0, ovf_o=0.
  - acc_o=0, and read data is 0 (absent bypass).
  - Reset mid-operation discards FIFO contents immediately.

## Timing
- Register writes are visible on reads one cycle later, or in the same cycle via bypass.
- Accumulate result appears on acc_o the cycle after we_i.
- FIFO has no fall-through: a pushed word is at the head and ext_avail_o=1 in the cycle after the push edge.
- ext_ready_o and ext_avail_o are registered-state decodes. There is no combinational path from ext_valid_i to ext_ready_o.
- Read outputs are combinational from the addresses, state and bypass inputs.
- Back-to-back ACCUM to the same accumulator every cycle is supported at full rate.

## Structure
- Package affine holds:
  - N.
  - typedef enum logic [1:0] wmode_t {SINGLE, BCAST, ACCUM, WM_RSV}.
  - A function sat_add(a, b) returning the sum and an overflow bit.
- Sub-module affine_ext_fifo (parameters N, EXT_DEPTH) holds the FIFO, count and handshake. The register array, write decode, bypass and ovf_o live in the top.

## Test plan
- Reset then idle: all outputs 0, ext_ready_o=1. Read addr 0 → 0.
- Push 4 words with EXT_DEPTH=4 → ext_ready_o=0, count=4. A 5th push is refused. Pop with push while full → count 3, the 5th word is not stored. Pop all → order preserved, then addr 0 reads 0.
- SINGLE write 0x1234 to temp 1 with rs_addr=1 in the same cycle → rs_data_o=0x1234 (bypass). Next cycle, still 0x1234.
- BCAST 0x0007 → every acc_o slice = 7 next cycle. A write to addr 0 leaves the FIFO head unchanged.
- With N=16, ACCUM of 0x7FF0 into acc 0 holding 0x0020 → acc=0x7FFF, ovf_o=1. Then clr_ovf_i alone → ovf_o=0. clr_ovf_i together with a new clamp → ovf_o stays 1.
- Assert rst_i asynchronously mid-stream with the FIFO holding 3 words → count 0 and ovf_o 0 immediately, without waiting for a clock edge.
